regfile_bank: RTL
=================

# regfile_bank

Parametrised general-purpose register file for the pipelined RISC core, replacing the fixed 16-bit, two-read-port register file in the decode stage. It adds a configurable read port count, same-cycle write-to-read bypass, a 2×DATA_W private register pair for saving the PC, and a multi-cycle bulk-clear sequencer with busy/done handshake.

## Interface
- DATA_W, 16, width of one register
- ADDR_W, 4, register address width
- NUM_REGS, 16, register count; must be ≤ 2**ADDR_W
- READ_PORTS, 2, number of independent read ports
- PRIV_IDX, 9, index of low half of private pair; high half at PRIV_IDX+1; PRIV_IDX+1 < NUM_REGS
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- read_addr  in  READ_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- read_data  out  READ_PORTS*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
- write_enable  in  1  GPR write strobe
- write_addr  in  ADDR_W  GPR write address
- write_data  in  DATA_W  GPR write data
- privateRegWrite  in  1  save PC into private pair
- PC  in  2*DATA_W  value saved on privateRegWrite
- privateRegResult  out  2*DATA_W  {reg[PRIV_IDX+1], reg[PRIV_IDX]}
- clear_req  in  1  start bulk clear
- clear_busy  out  1  bulk clear in progress
- clear_done  out  1  one-cycle pulse on clear completion

## Operation
- Storage: NUM_REGS × DATA_W flops. No hardwired-zero register.
- Reads combinational: read_data[p] = reg[read_addr[p]], with bypass: if write_enable, not clear_busy, and write_addr == read_addr[p], return write_data. Bypass also applies to privateRegWrite: addr PRIV_IDX returns PC[DATA_W-1:0], PRIV_IDX+1 returns PC[2*DATA_W-1:DATA_W]; write_enable bypass takes priority over PC bypass.
- Read/write address ≥ NUM_REGS: read returns 0; write ignored.
- privateRegResult: registered contents only (no bypass).
- Private write: on edge with privateRegWrite=1, reg[PRIV_IDX] ← PC low half, reg[PRIV_IDX+1] ← PC high half.
- Collision: write_enable to PRIV_IDX or PRIV_IDX+1 in same cycle as privateRegWrite → write_data wins for that register; other half takes PC.
- Clear FSM, states IDLE, CLEAR:
  - IDLE: clear_req=1 at edge → CLEAR, cnt ← 0.
  - CLEAR: each edge reg[cnt] ← 0, cnt ← cnt+1; on edge with cnt = NUM_REGS-1 → IDLE, clear_done ← 1.
  - clear_req ignored in CLEAR.
- While clear_busy=1, write_enable and privateRegWrite are ignored (no update, no bypass). Reads continue to return current contents (partly cleared).
- Writes on the edge that samples clear_req in IDLE are performed (then cleared later).

## Timing
- Reset (rst=0, async): all registers 0, state IDLE, cnt 0, clear_busy 0, clear_done 0; hence read_data and privateRegResult read 0 immediately.
- Write latency: 1 edge; bypass gives 0-cycle visibility on read ports.
- clear_req sampled at edge T: clear_busy high from after T through edge T+NUM_REGS; reg[k] zeroed at edge T+1+k; clear_done high exactly one cycle after edge T+NUM_REGS; clear_busy = (state == CLEAR).
- Back-to-back: clear_req high in the clear_done cycle starts a new clear.
- rst asserted mid-clear: immediate abort to IDLE, all registers 0, no clear_done.

## Test plan
- Reset then write reg3=0xBEEF at edge 1 → read port 0 addr 3 shows 0xBEEF in the write cycle (bypass) and after edge 1; port 1 addr 4 reads 0.
- privateRegWrite, PC=0x1234_5678 → privateRegResult=0x12345678 next cycle; reads of addr 9/10 = 0x5678/0x1234.
- privateRegWrite PC=0xAAAA_BBBB with write_enable addr 10 data 0x0F0F → reg10=0x0F0F, reg9=0xBBBB.
- Fill all 16 regs with idx+1, pulse clear_req → clear_busy 16 cycles, reg[k] zero after edge T+1+k, write attempt to reg2 during busy ignored, clear_done single pulse, all reads 0.
- rst low at cycle 5 of a clear → outputs 0 asynchronously, clear_busy 0, no clear_done.
- READ_PORTS=4, DATA_W=32 instance: four simultaneous reads of distinct and identical addresses return correct data; addr ≥ NUM_REGS reads 0.

Source files
------------

// File: rtl/regfile_bank.sv
// Parametrised GPR file: N combinational read ports with write/PC bypass,
// a private PC-save register pair and a sequential bulk-clear engine.
module regfile_bank #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned PRIV_IDX   = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [READ_PORTS*ADDR_W-1:0]   read_addr,
  output logic [READ_PORTS*DATA_W-1:0]   read_data,
  input  logic                           write_enable,
  input  logic [ADDR_W-1:0]              write_addr,
  input  logic [DATA_W-1:0]              write_data,
  input  logic                           privateRegWrite,
  input  logic [2*DATA_W-1:0]            PC,
  output logic [2*DATA_W-1:0]            privateRegResult,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           clear_done
);

  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PRIV_LO    = ADDR_W'(PRIV_IDX);
  localparam logic [ADDR_W-1:0] PRIV_HI    = ADDR_W'(PRIV_IDX + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                clr_en;
  logic                wr_ok, pw_ok;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // Writes are frozen for the whole clear sequence.
  assign wr_ok = write_enable && !clear_busy && ({1'b0, write_addr} < NUM_REGS_X);
  assign pw_ok = privateRegWrite && !clear_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (cnt_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    clr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) cnt_d = '0;
      end
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;

  // GPR write takes priority over the PC save on a colliding address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      if (clr_en) regs[cnt_q] <= '0;
      if (pw_ok) begin
        regs[PRIV_IDX]     <= PC[DATA_W-1:0];
        regs[PRIV_IDX + 1] <= PC[2*DATA_W-1:DATA_W];
      end
      if (wr_ok) regs[write_addr] <= write_data;
    end
  end

  for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = read_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      if ({1'b0, addr} < NUM_REGS_X) begin
        if (wr_ok && (write_addr == addr))  data = write_data;
        else if (pw_ok && (addr == PRIV_LO)) data = PC[DATA_W-1:0];
        else if (pw_ok && (addr == PRIV_HI)) data = PC[2*DATA_W-1:DATA_W];
        else                                 data = regs[addr];
      end
    end

    assign read_data[p*DATA_W +: DATA_W] = data;
  end

  assign privateRegResult = {regs[PRIV_IDX + 1], regs[PRIV_IDX]};

endmodule
